// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: holds M, P and the iteration counter,
// and executes the register transfers strobed by the control unit.
module mult_datapath #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic               init,
   input  logic               l_lsb,
   input  logic               lsb_sel,
   input  logic               shift_load,
   input  logic               finish_cycle,
   output logic [2*WIDTH-1:0] product,
   output logic               product_valid,
   output logic               i_eq_0,
   output logic               p_lsb
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]   m_q, m_d;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               lsb_q, lsb_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic               vld_q, vld_d;

   logic               gate;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     sum;

   // A same-cycle l_lsb bypasses the latch so one-cycle iterations work.
   assign gate   = l_lsb ? p_q[0] : lsb_q;
   assign addend = (lsb_sel && gate) ? m_q : '0;
   assign sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

   always_comb begin
      m_d   = m_q;
      p_d   = p_q;
      cnt_d = cnt_q;
      lsb_d = lsb_q;
      prod_d = prod_q;
      vld_d = 1'b0;
      if (init) begin
         m_d   = multiplicand;
         p_d   = {{WIDTH{1'b0}}, multiplier};
         cnt_d = CW'(WIDTH);
         lsb_d = 1'b0;
      end else begin
         if (l_lsb) begin
            lsb_d = p_q[0];
         end
         if (shift_load && (cnt_q != '0)) begin
            p_d   = {sum, p_q[WIDTH-1:1]};
            cnt_d = cnt_q - CW'(1);
         end
         // Samples P as it was before any same-cycle iteration.
         if (finish_cycle) begin
            prod_d = p_q;
            vld_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q    <= '0;
         p_q    <= '0;
         cnt_q  <= '0;
         lsb_q  <= 1'b0;
         prod_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         m_q    <= m_d;
         p_q    <= p_d;
         cnt_q  <= cnt_d;
         lsb_q  <= lsb_d;
         prod_q <= prod_d;
         vld_q  <= vld_d;
      end
   end

   assign product       = prod_q;
   assign product_valid = vld_q;
   assign i_eq_0        = (cnt_q == '0);
   assign p_lsb         = lsb_q;

endmodule

// File: doc/mult_datapath.md
# mult_datapath

Shift-add multiplier datapath: the responder side of the multiplier control interface. It holds the multiplicand, partial product and iteration counter, executes the register transfers commanded by the control unit's `init`, `lsb_sel`, `shift_load`, `l_lsb` and `finish_cycle` strobes, and returns `i_eq_0` and `p_lsb` as status. Together with the control unit it forms the complete sequential multiplier.

## Interface
- `WIDTH`, 32, operand width in bits; product is 2*WIDTH.
- `clk` input 1 rising-edge clock.
- `rst_n` input 1 asynchronous active-low reset.
- `multiplicand` input WIDTH operand M, sampled on `init`.
- `multiplier` input WIDTH operand Q, sampled on `init`.
- `init` input 1 load operands, reload counter.
- `l_lsb` input 1 latch P[0] into `p_lsb`.
- `lsb_sel` input 1 add gate enable: 1 = add M when gating bit is 1; 0 = add zero (pure shift).
- `shift_load` input 1 perform one add-and-shift iteration.
- `finish_cycle` input 1 copy P to `product`, pulse `product_valid`.
- `product` output 2*WIDTH result register.
- `product_valid` output 1 one-cycle pulse after `finish_cycle`.
- `i_eq_0` output 1 high when iteration counter is 0.
- `p_lsb` output 1 latched LSB of P.

## Operation
- Registers: M (WIDTH), P (2*WIDTH), counter (clog2(WIDTH+1) bits), `p_lsb`, `product`, `product_valid`.
- `init`: M <= multiplicand; P <= {WIDTH'b0, multiplier}; counter <= WIDTH; `p_lsb` <= 0.
- `l_lsb`: `p_lsb` <= P[0].
- `shift_load` with counter != 0: gating bit g = `l_lsb` ? P[0] : `p_lsb` (bypass when both asserted in one cycle). Addend A = (`lsb_sel` & g) ? M : 0. Sum S = {1'b0, P[2W-1:W]} + {1'b0, A} (WIDTH+1 bits, carry kept). P <= {S, P[W-1:1]}; counter <= counter - 1.
- `shift_load` with counter == 0: ignored; P and counter hold.
- `finish_cycle`: `product` <= P; `product_valid` <= 1 next cycle only; otherwise `product_valid` <= 0.
- Precedence: `init` overrides all other strobes in the same cycle; `finish_cycle` samples P before any same-cycle update.
- `i_eq_0` = (counter == 0), combinational from the counter register.
- Nominal control sequence: `init`; WIDTH times {`l_lsb`, then `lsb_sel`+`shift_load`}; `finish_cycle` once `i_eq_0` is seen. Single-cycle {`l_lsb`+`lsb_sel`+`shift_load`} iterations are also legal via the bypass.

## Timing
- Reset (async assert, sync release on next edge): M=0, P=0, counter=0, `product`=0, `product_valid`=0, `p_lsb`=0, hence `i_eq_0`=1.
- All register updates on the rising `clk` edge; outputs are valid in the cycle after the strobe.
- `i_eq_0` falls the cycle after `init` and rises the cycle after the WIDTH-th effective `shift_load`.
- Latency, nominal sequence: 1 (`init`) + 2*WIDTH + 1 (`finish_cycle`) cycles to `product_valid`; with single-cycle iterations, WIDTH + 2.
- `init` mid-operation restarts cleanly; `product` keeps its last value until the next `finish_cycle`.
- `rst_n` low mid-operation clears everything immediately, regardless of `clk`.
- No strobe asserted: all registers hold, except `product_valid`, which returns to 0.

## Test plan
- WIDTH=32, M=3, Q=5, nominal 2-cycle iterations -> `i_eq_0` high after the 32nd shift; `product`=0x0000_0000_0000_000F, `product_valid` high for exactly 1 cycle.
- M=Q=0xFFFF_FFFF, single-cycle iterations -> `product`=0xFFFF_FFFE_0000_0001 at cycle WIDTH+2 (carry path exercised).
- M=7, Q=9, `lsb_sel`=0 for all 32 iterations -> `product`=0; extra `shift_load` pulses with `i_eq_0`=1 leave P unchanged.
- `init` asserted mid-run (after 10 shifts) with M=6, Q=7, same cycle as `shift_load` -> restart, counter reloads to 32; final `product`=42.
- `rst_n` pulsed low between clock edges mid-run -> all outputs 0 and `i_eq_0`=1 immediately; a following full run with M=0x1234, Q=0x10 gives `product`=0x12340.
- `finish_cycle` asserted with no prior `init` after reset -> `product`=0, `product_valid` pulses once.
